// File: rtl/reg_writeback.sv
// Register-file write front end: merges ALU and queued load results into one write per cycle,
// with read-port forwarding of the in-flight write and busy flags for queued loads.
module reg_writeback #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [WIDTH-1:0] ld_data,
    output logic             RegWrite,
    output logic [4:0]       WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    input  logic [WIDTH-1:0] rf_data1,
    input  logic [WIDTH-1:0] rf_data2,
    output logic [WIDTH-1:0] fwd_data1,
    output logic [WIDTH-1:0] fwd_data2,
    output logic             busy1,
    output logic             busy2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [4:0]    XZR        = 5'd31;

    logic [4:0]       q_rd   [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [SW-1:0]    sc;

    logic head_live, head_dead, starved;
    logic alu_wr, ld_push, write_head, pop;

    assign head_live  = (count != '0) && q_live[head];
    assign head_dead  = (count != '0) && !q_live[head];
    assign starved    = head_live && (sc == STARVE_MAX);
    assign alu_ready  = !rst && !starved;
    assign ld_ready   = !rst && (count != FULL);
    assign alu_wr     = alu_valid && alu_ready && (alu_rd != XZR);
    assign ld_push    = ld_valid && ld_ready && (ld_rd != XZR);
    // A starved head already blocks the ALU, so "head wins" reduces to "no ALU write".
    assign write_head = head_live && !alu_wr;
    assign pop        = head_dead || write_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            sc            <= '0;
            q_live        <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= alu_wr || write_head;
            if (write_head) begin
                WriteRegister <= q_rd[head];
                WriteData     <= q_data[head];
            end else if (alu_wr) begin
                WriteRegister <= alu_rd;
                WriteData     <= alu_data;
            end

            // Older queued loads to the same register are superseded by this ALU write.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr && (q_rd[i] == alu_rd))
                    q_live[i] <= 1'b0;
            end
            if (pop) begin
                q_live[head] <= 1'b0;
                head         <= head + PW'(1);
            end
            if (ld_push) begin
                q_live[tail] <= 1'b1;
                tail         <= tail + PW'(1);
            end

            case ({ld_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if ((count == '0) || pop)
                sc <= '0;
            else if (head_live && (sc != STARVE_MAX))
                sc <= sc + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready && (ld_rd != XZR)) begin
            q_rd[tail]   <= ld_rd;
            q_data[tail] <= ld_data;
        end
    end

    assign fwd_data1 = (RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != XZR))
                       ? WriteData : rf_data1;
    assign fwd_data2 = (RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != XZR))
                       ? WriteData : rf_data2;

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i] && (q_rd[i] == ReadRegister1) && (ReadRegister1 != XZR))
                busy1 = 1'b1;
            if (q_live[i] && (q_rd[i] == ReadRegister2) && (ReadRegister2 != XZR))
                busy2 = 1'b1;
        end
    end
endmodule
